i2s_rx_dma_ctrl: RTL and testbench

//  Drain sequencer between the I2S receive FIFO (32x32) and a single-beat memory write port.

---
 rtl/i2s_rx_dma_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_i2s_rx_dma_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_dma_ctrl.sv
// I2S receive FIFO drain sequencer: pops bursts of samples and writes them into a circular
// memory buffer over a single-beat req/ack port. Optional 16-bit packing under I2S_DMA_PACK16_EN.
module i2s_rx_dma_ctrl #(
  parameter int AW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    base_addr,
  input  logic [CNT_W-1:0] buf_words,
  input  logic [4:0]       burst_len,
  input  logic             pack16,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic [4:0]       fifo_level,
  input  logic [31:0]      fifo_rdata,
  output logic             fifo_rd,
  output logic             dma_req,
  output logic [AW-1:0]    dma_addr,
  output logic [31:0]      dma_wdata,
  input  logic             dma_ack,
  output logic             busy,
  output logic             half_irq,
  output logic             wrap_irq,
  output logic [2:0]       dbg_state
);

  // Handshake: dma_req, dma_addr and dma_wdata stay constant from the first REQ cycle until
  // the rising edge on which dma_ack is sampled high; that edge completes the transfer.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_POP    = 3'd2,
    S_REQ    = 3'd3
`ifdef I2S_DMA_PACK16_EN
    ,
    S_POP_LO = 3'd4,
    S_POP_HI = 3'd5
`endif
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:2]    base_q;
  logic [CNT_W-1:0] bw_q;
  logic [4:0]       bl_q;
  logic [CNT_W-1:0] idx_q;
  logic [4:0]       beat_q;
  logic [31:0]      data_q;

  logic [CNT_W-1:0] bw_eff;
  logic [4:0]       bl_eff;
  logic             pack_in;
  logic             pack_q;
  logic [5:0]       need;
  logic             burst_ready;
  logic             start_burst;
  logic             ack_xfer;
  logic             last_beat;
  logic             idx_last;
  logic [CNT_W-1:0] idx_inc;
  logic [CNT_W-1:0] half_mark;

  assign bw_eff = (buf_words < CNT_W'(2)) ? CNT_W'(2) : buf_words;
  assign bl_eff = (burst_len == 5'd0) ? 5'd1 :
                  (burst_len > 5'd16) ? 5'd16 : burst_len;

`ifdef I2S_DMA_PACK16_EN
  assign pack_in = pack16;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^base_addr[1:0];
`else
  assign pack_in = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{base_addr[1:0], pack16};
`endif

  // fifo_level wraps to 0 at 32 entries, so fifo_full covers that case.
  assign need        = pack_in ? {bl_eff, 1'b0} : {1'b0, bl_eff};
  assign burst_ready = fifo_full || ({1'b0, fifo_level} >= need);

  assign last_beat = ((beat_q + 5'd1) == bl_q);
  assign idx_last  = (idx_q == (bw_q - CNT_W'(1)));
  assign idx_inc   = idx_q + CNT_W'(1);
  assign half_mark = bw_q >> 1;

  always_comb begin
    state_d     = state_q;
    fifo_rd     = 1'b0;
    dma_req     = 1'b0;
    start_burst = 1'b0;
    ack_xfer    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (burst_ready) begin
          start_burst = 1'b1;
`ifdef I2S_DMA_PACK16_EN
          state_d = pack_in ? S_POP_LO : S_POP;
`else
          state_d = S_POP;
`endif
        end
      end
      S_POP: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = S_REQ;
        end
      end
`ifdef I2S_DMA_PACK16_EN
      S_POP_LO: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = S_POP_HI;
        end
      end
      // The low half is already consumed, so finish the word even if en drops.
      S_POP_HI: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = S_REQ;
        end
      end
`endif
      S_REQ: begin
        dma_req = 1'b1;
        if (dma_ack) begin
          ack_xfer = 1'b1;
          if (!en) begin
            state_d = S_IDLE;
          end else if (last_beat) begin
            state_d = S_WAIT;
          end else begin
`ifdef I2S_DMA_PACK16_EN
            state_d = pack_q ? S_POP_LO : S_POP;
`else
            state_d = S_POP;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      bw_q     <= CNT_W'(2);
      bl_q     <= 5'd1;
      pack_q   <= 1'b0;
      idx_q    <= '0;
      beat_q   <= '0;
      data_q   <= '0;
      half_irq <= 1'b0;
      wrap_irq <= 1'b0;
    end else begin
      half_irq <= 1'b0;
      wrap_irq <= 1'b0;
      if (state_q == S_IDLE && en) begin
        idx_q  <= '0;
        beat_q <= '0;
      end
      if (start_burst) begin
        base_q <= base_addr[AW-1:2];
        bw_q   <= bw_eff;
        bl_q   <= bl_eff;
        pack_q <= pack_in;
      end
      if (fifo_rd) begin
`ifdef I2S_DMA_PACK16_EN
        if (state_q == S_POP_LO)      data_q[15:0]  <= fifo_rdata[15:0];
        else if (state_q == S_POP_HI) data_q[31:16] <= fifo_rdata[15:0];
        else                          data_q        <= fifo_rdata;
`else
        data_q <= fifo_rdata;
`endif
      end
      if (ack_xfer) begin
        if (idx_last) begin
          idx_q    <= '0;
          wrap_irq <= 1'b1;
        end else begin
          idx_q <= idx_inc;
          if (idx_inc == half_mark) half_irq <= 1'b1;
        end
        beat_q <= last_beat ? 5'd0 : beat_q + 5'd1;
      end
    end
  end

`ifndef I2S_DMA_PACK16_EN
  logic unused_pack_q;
  assign unused_pack_q = pack_q;
`endif

  assign dma_addr  = dma_req ? ({base_q, 2'b00} + AW'({idx_q, 2'b00})) : '0;
  assign dma_wdata = dma_req ? data_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2s_rx_dma_ctrl.sv
// Directed bench for i2s_rx_dma_ctrl: behavioural FIFO model, write scoreboard and
// immediate-assertion checks over a linear sequence of scenarios.
module tb_i2s_rx_dma_ctrl;

  localparam int AW    = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             en;
  logic [AW-1:0]    base_addr;
  logic [CNT_W-1:0] buf_words;
  logic [4:0]       burst_len;
  logic             pack16;
  logic             fifo_empty;
  logic             fifo_full;
  logic [4:0]       fifo_level;
  logic [31:0]      fifo_rdata;
  logic             fifo_rd;
  logic             dma_req;
  logic [AW-1:0]    dma_addr;
  logic [31:0]      dma_wdata;
  logic             dma_ack;
  logic             busy;
  logic             half_irq;
  logic             wrap_irq;
  logic [2:0]       dbg_state;

  i2s_rx_dma_ctrl #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .base_addr(base_addr), .buf_words(buf_words), .burst_len(burst_len), .pack16(pack16),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .busy(busy), .half_irq(half_irq), .wrap_irq(wrap_irq), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]   fifo_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_q[$];

  int total = 0;
  int bad   = 0;
  int pop_cnt, wr_cnt, half_cnt, wrap_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_full  = (fifo_q.size() >= 32);
    fifo_level = 5'(fifo_q.size());
    fifo_rdata = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
  endtask

  task automatic push(input logic [31:0] d);
    fifo_q.push_back(d);
    drive_fifo();
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_q.push_back(d);
  endtask

  task automatic clear_counts();
    pop_cnt = 0; wr_cnt = 0; half_cnt = 0; wrap_cnt = 0;
  endtask

  // One cycle: observe on the falling edge, apply FIFO pop just after the rising edge.
  task automatic tick();
    logic pop_now;
    @(negedge clk);
    pop_now = fifo_rd;
    if (fifo_rd) begin
      pop_cnt++;
      check("rd_not_empty", fifo_empty, 1'b0);
    end
    if (half_irq) half_cnt++;
    if (wrap_irq) wrap_cnt++;
    if (half_irq || wrap_irq) check("irq_exclusive", half_irq & wrap_irq, 1'b0);
    if (dma_req && dma_ack) begin
      wr_cnt++;
      check("wr_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        check("wr_addr", dma_addr, exp_addr_q.pop_front());
        check("wr_data", dma_wdata, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic restart();
    en = 1'b0;
    run(3);
    check("restart_idle", dbg_state, 3'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dma_ack = 1'b1; pack16 = 1'b0;
    base_addr = 32'h1000; buf_words = 16'd8; burst_len = 5'd4;
    clear_counts();
    drive_fifo();
    run(3);

    // reset state
    check("rst_fifo_rd", fifo_rd, 1'b0);
    check("rst_dma_req", dma_req, 1'b0);
    check("rst_dma_addr", dma_addr, 32'h0);
    check("rst_dma_wdata", dma_wdata, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_irqs", {half_irq, wrap_irq}, 2'b00);
    check("rst_state", dbg_state, 3'd0);
    rst = 1'b0;
    run(2);

    // below threshold: 3 of 4 samples, nothing moves
    push(32'hA0); push(32'hA1); push(32'hA2);
    en = 1'b1;
    run(10);
    check("thr_no_pop", pop_cnt, 0);
    check("thr_no_wr", wr_cnt, 0);
    check("thr_req_low", dma_req, 1'b0);
    check("thr_busy", busy, 1'b1);

    // 4th sample starts the burst
    for (int i = 0; i < 4; i++) expect_wr(32'h1000 + 4 * i, 32'hA0 + i);
    push(32'hA3);
    run(12);
    check("b1_writes", wr_cnt, 4);
    check("b1_pops", pop_cnt, 4);
    check("b1_half", half_cnt, 1);
    check("b1_wrap", wrap_cnt, 0);
    check("b1_sb_drained", exp_q.size(), 0);
    check("b1_wait", dbg_state, 3'd1);

    // streaming 12 words through an 8-word buffer
    restart();
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      push(32'hB0 + i);
      expect_wr(32'h1000 + 4 * (i % 8), 32'hB0 + i);
    end
    en = 1'b1;
    run(40);
    check("wrap_writes", wr_cnt, 12);
    check("wrap_irq_cnt", wrap_cnt, 1);
    check("wrap_half_cnt", half_cnt, 2);
    check("wrap_sb_drained", exp_q.size(), 0);

    // full FIFO (level reads 0) with 16-beat bursts
    restart();
    clear_counts();
    burst_len = 5'd16; buf_words = 16'd64;
    for (int i = 0; i < 32; i++) begin
      push(32'hC000_0000 + i);
      expect_wr(32'h1000 + 4 * i, 32'hC000_0000 + i);
    end
    check("full_level_zero", {fifo_full, fifo_level}, 6'b100000);
    en = 1'b1;
    run(80);
    check("full_writes", wr_cnt, 32);
    check("full_pops", pop_cnt, 32);
    check("full_half", half_cnt, 1);
    check("full_sb_drained", exp_q.size(), 0);

    // clamps: burst 0 -> 1, buf_words 1 -> 2, address LSBs ignored
    restart();
    clear_counts();
    burst_len = 5'd0; buf_words = 16'd1; base_addr = 32'h2003;
    push(32'hE0); push(32'hE1);
    expect_wr(32'h2000, 32'hE0);
    expect_wr(32'h2004, 32'hE1);
    en = 1'b1;
    run(12);
    check("clamp_writes", wr_cnt, 2);
    check("clamp_half", half_cnt, 1);
    check("clamp_wrap", wrap_cnt, 1);
    check("clamp_sb_drained", exp_q.size(), 0);

    // ack stall, then en dropped during the stall
    restart();
    clear_counts();
    base_addr = 32'h1000; buf_words = 16'd8; burst_len = 5'd4; dma_ack = 1'b0;
    for (int i = 0; i < 6; i++) push(32'hD0 + i);
    en = 1'b1;
    for (int i = 0; i < 20 && !dma_req; i++) tick();
    check("stall_req_seen", dma_req, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_req", dma_req, 1'b1);
      check("stall_addr", dma_addr, 32'h1000);
      check("stall_data", dma_wdata, 32'hD0);
    end
    en = 1'b0;
    run(3);
    check("stall_req_kept", dma_req, 1'b1);
    check("stall_state_req", dbg_state, 3'd3);
    expect_wr(32'h1000, 32'hD0);
    dma_ack = 1'b1;
    run(3);
    check("stall_idle", dbg_state, 3'd0);
    check("stall_busy", busy, 1'b0);
    check("stall_writes", wr_cnt, 1);
    check("stall_pops", pop_cnt, 1);
    check("stall_fifo_left", fifo_q.size(), 5);
    check("stall_sb_drained", exp_q.size(), 0);

    // pack16 request
    fifo_q.delete();
    drive_fifo();
    restart();
    clear_counts();
    burst_len = 5'd2; pack16 = 1'b1;
    push(32'h1111); push(32'h2222); push(32'h3333); push(32'h4444);
`ifdef I2S_DMA_PACK16_EN
    expect_wr(32'h1000, 32'h2222_1111);
    expect_wr(32'h1004, 32'h4444_3333);
    en = 1'b1;
    run(15);
    check("pack_writes", wr_cnt, 2);
`else
    expect_wr(32'h1000, 32'h1111);
    expect_wr(32'h1004, 32'h2222);
    expect_wr(32'h1008, 32'h3333);
    expect_wr(32'h100C, 32'h4444);
    en = 1'b1;
    run(15);
    check("nopack_writes", wr_cnt, 4);
`endif
    check("pack_pops", pop_cnt, 4);
    check("pack_sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
